// File: rtl/reg_pipe_stage_b_pkg.sv
// Shared types, sizing constants and helpers for the execute stage and its MUL/DIV unit.
package reg_pipe_stage_b_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned MD_ITER = 16;
    localparam int unsigned CNT_W = $clog2(MD_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);
    localparam logic [DATA_W-1:0] DIV0_QUOT = 16'hFFFF;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_PASS,
        ALU_MUL,
        ALU_DIV
    } control_e;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    function automatic logic is_md(control_e op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    // 0x8000 maps to 0x8000, which is correct when read as unsigned.
    function automatic logic [DATA_W-1:0] abs_w(logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? ((~x) + 1'b1) : x;
    endfunction

endpackage

// File: rtl/reg_pipe_stage_b_if.sv
// Stage-A -> execute inputs, stall back-pressure and EX/MEM register outputs.
interface reg_pipe_stage_b_if;
    import reg_pipe_stage_b_pkg::*;

    logic [1:0]        in_memc;
    logic              in_reg_wr;
    logic [DATA_W-1:0] in_alu_a;
    logic [DATA_W-1:0] in_alu_b;
    logic [DATA_W-1:0] in_R1_data;
    logic              in_R0_en;
    control_e          in_alu_ctrl;
    logic [7:0]        in_instr;

    logic              stall;
    logic [1:0]        out_memc;
    logic              out_reg_wr;
    logic [DATA_W-1:0] out_alu_result;
    logic [DATA_W-1:0] out_R0_data;
    logic              out_R0_en;
    logic [DATA_W-1:0] out_R1_data;
    logic [7:0]        out_instr;
    logic              out_div0;

    modport master (
        output in_memc, in_reg_wr, in_alu_a, in_alu_b, in_R1_data, in_R0_en, in_alu_ctrl,
               in_instr,
        input  stall, out_memc, out_reg_wr, out_alu_result, out_R0_data, out_R0_en,
               out_R1_data, out_instr, out_div0
    );

    modport slave (
        input  in_memc, in_reg_wr, in_alu_a, in_alu_b, in_R1_data, in_R0_en, in_alu_ctrl,
               in_instr,
        output stall, out_memc, out_reg_wr, out_alu_result, out_R0_data, out_R0_en,
               out_R1_data, out_instr, out_div0
    );

endinterface

// File: rtl/reg_pipe_stage_b_mul_div.sv
// Iterative signed MUL (shift-add) / DIV (restoring), one bit per cycle on magnitudes.
module reg_pipe_stage_b_mul_div
    import reg_pipe_stage_b_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_halt,
    input  logic              i_start,
    input  logic              i_div,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_last,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    md_state_e           r_state, w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic                r_div, r_neg_lo, r_neg_hi;
    logic [DATA_W-1:0]   r_hi, r_lo, r_m;
    logic [DATA_W:0]     w_sum, w_sh, w_diff;
    logic [DATA_W-1:0]   w_nhi, w_nlo;
    logic [2*DATA_W-1:0] w_prod, w_prod_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else if (!i_halt) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_state_next = MD_BUSY;
            MD_BUSY: if (r_count == CNT_LAST) w_state_next = MD_IDLE;
            default: w_state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == MD_BUSY);
        o_last = (r_state == MD_BUSY) && (r_count == CNT_LAST);
    end

    // One iteration: r_hi is partial product / remainder, r_lo is multiplier / quotient.
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_sh   = {r_hi, r_lo[DATA_W-1]};
        w_diff = w_sh - {1'b0, r_m};
        if (r_div) begin
            w_nhi = w_diff[DATA_W] ? w_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
            w_nlo = {r_lo[DATA_W-2:0], ~w_diff[DATA_W]};
        end else begin
            w_nhi = w_sum[DATA_W:1];
            w_nlo = {w_sum[0], r_lo[DATA_W-1:1]};
        end
        w_prod     = {w_nhi, w_nlo};
        w_prod_fix = r_neg_lo ? ((~w_prod) + 1'b1) : w_prod;
        if (r_div) begin
            o_lo = r_neg_lo ? ((~w_nlo) + 1'b1) : w_nlo;
            o_hi = r_neg_hi ? ((~w_nhi) + 1'b1) : w_nhi;
        end else begin
            o_lo = w_prod_fix[DATA_W-1:0];
            o_hi = w_prod_fix[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
        end else if (!i_halt) begin
            if ((r_state == MD_IDLE) && i_start) begin
                r_count  <= '0;
                r_div    <= i_div;
                r_hi     <= '0;
                r_lo     <= i_div ? abs_w(i_a) : abs_w(i_b);
                r_m      <= i_div ? abs_w(i_b) : abs_w(i_a);
                r_neg_lo <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
                r_neg_hi <= i_a[DATA_W-1];
            end else if (r_state == MD_BUSY) begin
                r_hi    <= w_nhi;
                r_lo    <= w_nlo;
                r_count <= (r_count == CNT_LAST) ? '0 : r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_pipe_stage_b.sv
// Execute stage with EX/MEM register; stalls stage A while the MUL/DIV unit iterates.
module reg_pipe_stage_b
    import reg_pipe_stage_b_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_sys,
    reg_pipe_stage_b_if.slave  bus
);

    logic              w_is_md, w_div0, w_start, w_busy, w_last, w_stall;
    logic [DATA_W-1:0] w_alu_res, w_md_hi, w_md_lo;

    assign w_is_md = is_md(bus.in_alu_ctrl);
    assign w_div0  = (bus.in_alu_ctrl == ALU_DIV) && (bus.in_alu_b == '0);
    assign w_start = !w_busy && w_is_md && !w_div0;
    assign w_stall = !rst && (w_start || (w_busy && !w_last));
    assign bus.stall = w_stall;

    reg_pipe_stage_b_mul_div u_mul_div (
        .clk     (clk),
        .rst     (rst),
        .i_halt  (halt_sys),
        .i_start (w_start),
        .i_div   (bus.in_alu_ctrl == ALU_DIV),
        .i_a     (bus.in_alu_a),
        .i_b     (bus.in_alu_b),
        .o_busy  (w_busy),
        .o_last  (w_last),
        .o_hi    (w_md_hi),
        .o_lo    (w_md_lo)
    );

    always_comb begin
        w_alu_res = '0;
        case (bus.in_alu_ctrl)
            ALU_ADD:  w_alu_res = bus.in_alu_a + bus.in_alu_b;
            ALU_SUB:  w_alu_res = bus.in_alu_a - bus.in_alu_b;
            ALU_AND:  w_alu_res = bus.in_alu_a & bus.in_alu_b;
            ALU_OR:   w_alu_res = bus.in_alu_a | bus.in_alu_b;
            ALU_XOR:  w_alu_res = bus.in_alu_a ^ bus.in_alu_b;
            ALU_SLL:  w_alu_res = bus.in_alu_a << bus.in_alu_b[3:0];
            ALU_SRL:  w_alu_res = bus.in_alu_a >> bus.in_alu_b[3:0];
            ALU_SRA:  w_alu_res = $unsigned($signed(bus.in_alu_a) >>> bus.in_alu_b[3:0]);
            ALU_PASS: w_alu_res = bus.in_alu_b;
            default:  w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_memc       <= '0;
            bus.out_reg_wr     <= 1'b0;
            bus.out_alu_result <= '0;
            bus.out_R0_data    <= '0;
            bus.out_R0_en      <= 1'b0;
            bus.out_R1_data    <= '0;
            bus.out_instr      <= '0;
            bus.out_div0       <= 1'b0;
        end else if (!halt_sys) begin
            if (w_stall) begin
                // Bubble: data fields hold, only controls are squashed.
                bus.out_memc   <= '0;
                bus.out_reg_wr <= 1'b0;
                bus.out_R0_en  <= 1'b0;
                bus.out_instr  <= '0;
                bus.out_div0   <= 1'b0;
            end else begin
                bus.out_memc    <= bus.in_memc;
                bus.out_reg_wr  <= bus.in_reg_wr;
                bus.out_R1_data <= bus.in_R1_data;
                bus.out_instr   <= bus.in_instr;
                if (w_last) begin
                    bus.out_alu_result <= w_md_lo;
                    bus.out_R0_data    <= w_md_hi;
                    bus.out_R0_en      <= 1'b1;
                    bus.out_div0       <= 1'b0;
                end else if (w_div0) begin
                    bus.out_alu_result <= DIV0_QUOT;
                    bus.out_R0_data    <= bus.in_alu_a;
                    bus.out_R0_en      <= bus.in_R0_en;
                    bus.out_div0       <= 1'b1;
                end else begin
                    bus.out_alu_result <= w_alu_res;
                    bus.out_R0_data    <= '0;
                    bus.out_R0_en      <= bus.in_R0_en;
                    bus.out_div0       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_pipe_stage_b.sv
// Directed + random bench for reg_pipe_stage_b against an arithmetic reference model.
module tb_reg_pipe_stage_b;
    import reg_pipe_stage_b_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic halt_sys;
    int   n_vec = 0;
    int   n_err = 0;

    reg_pipe_stage_b_if bus();

    reg_pipe_stage_b dut (
        .clk      (clk),
        .rst      (rst),
        .halt_sys (halt_sys),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_out();
        return {19'b0, bus.out_memc, bus.out_reg_wr, bus.out_R0_en, bus.out_div0, bus.out_instr};
    endfunction

    task automatic drive(input control_e op, input logic [15:0] a, input logic [15:0] b);
        bus.in_alu_ctrl = op;
        bus.in_alu_a    = a;
        bus.in_alu_b    = b;
        bus.in_memc     = 2'($urandom_range(0, 3));
        bus.in_reg_wr   = 1'($urandom_range(0, 1));
        bus.in_R0_en    = 1'($urandom_range(0, 1));
        bus.in_R1_data  = 16'($urandom);
        bus.in_instr    = 8'($urandom_range(1, 255));
    endtask

    // Expected EX/MEM contents from the instruction semantics alone.
    task automatic model(output logic [15:0] res, output logic [15:0] r0, output logic r0en,
                         output logic div0, output int stalls);
        longint sa, sb, p, q, r;
        logic [15:0] ua, ub;
        ua = bus.in_alu_a;
        ub = bus.in_alu_b;
        sa = longint'($signed(ua));
        sb = longint'($signed(ub));
        p = 0; q = 0; r = 0;
        r0 = 16'h0; r0en = bus.in_R0_en; div0 = 1'b0; stalls = 0;
        case (bus.in_alu_ctrl)
            ALU_ADD:  p = sa + sb;
            ALU_SUB:  p = sa - sb;
            ALU_AND:  p = longint'(ua & ub);
            ALU_OR:   p = longint'(ua | ub);
            ALU_XOR:  p = longint'(ua ^ ub);
            ALU_SLL:  p = longint'(ua) << ub[3:0];
            ALU_SRL:  p = longint'(ua) >> ub[3:0];
            ALU_SRA:  p = sa >>> ub[3:0];
            ALU_PASS: p = longint'(ub);
            ALU_MUL: begin
                p = sa * sb;
                r0 = p[31:16]; r0en = 1'b1; stalls = MD_ITER;
            end
            ALU_DIV: begin
                if (ub == 16'h0) begin
                    p = longint'(16'hFFFF); r0 = ua; div0 = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    p = q; r0 = r[15:0]; r0en = 1'b1; stalls = MD_ITER;
                end
            end
            default: p = 0;
        endcase
        res = p[15:0];
    endtask

    task automatic check_result(input string tag, input logic [15:0] er, input logic [15:0] e0,
                                input logic een, input logic ed);
        chk({tag, ".result"}, 32'(bus.out_alu_result), 32'(er));
        chk({tag, ".R0_data"}, 32'(bus.out_R0_data), 32'(e0));
        chk({tag, ".ctrl"}, ctrl_out(),
            {19'b0, bus.in_memc, bus.in_reg_wr, een, ed, bus.in_instr});
        chk({tag, ".R1_data"}, 32'(bus.out_R1_data), 32'(bus.in_R1_data));
    endtask

    task automatic apply(input string tag, input control_e op, input logic [15:0] a,
                         input logic [15:0] b);
        logic [15:0] er, e0;
        logic een, ed;
        int es, n_st;
        drive(op, a, b);
        model(er, e0, een, ed, es);
        n_st = 0;
        @(negedge clk);
        while (bus.stall && n_st < 40) begin
            n_st++;
            @(posedge clk); #1;
            chk({tag, ".bubble"}, ctrl_out(), 32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        check_result(tag, er, e0, een, ed);
        chk({tag, ".stall_cycles"}, 32'(n_st), 32'(es));
    endtask

    initial begin
        logic [15:0] er, e0;
        logic een, ed;
        int es, n_st;
        logic [31:0] snap_data, snap_ctrl;
        control_e op;
        logic [15:0] ra, rb;

        rst = 1'b1;
        halt_sys = 1'b0;
        drive(ALU_ADD, 16'h0, 16'h0);
        #2;
        chk("reset.result", 32'(bus.out_alu_result), 32'h0);
        chk("reset.R0_data", 32'(bus.out_R0_data), 32'h0);
        chk("reset.ctrl", ctrl_out(), 32'h0);
        chk("reset.stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        apply("add", ALU_ADD, 16'd3, 16'd4);
        apply("mul", ALU_MUL, 16'd300, 16'hFFFE);
        apply("div_neg", ALU_DIV, 16'hFFF9, 16'd2);
        apply("div0", ALU_DIV, 16'd5, 16'h0);
        apply("b2b_mul", ALU_MUL, 16'h8000, 16'h8000);
        apply("b2b_div", ALU_DIV, 16'd1000, 16'hFFF9);
        apply("div_wrap", ALU_DIV, 16'h8000, 16'hFFFF);
        apply("sra", ALU_SRA, 16'h8F00, 16'd4);

        // Halt for four cycles once the unit reaches count 5.
        drive(ALU_MUL, 16'd1234, 16'hFFC9);
        model(er, e0, een, ed, es);
        n_st = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.stall) n_st++;
            @(posedge clk); #1;
        end
        snap_data = {bus.out_alu_result, bus.out_R0_data};
        snap_ctrl = ctrl_out();
        halt_sys = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.stall) n_st++;
            @(posedge clk); #1;
            chk("halt.data_frozen", {bus.out_alu_result, bus.out_R0_data}, snap_data);
            chk("halt.ctrl_frozen", ctrl_out(), snap_ctrl);
        end
        halt_sys = 1'b0;
        @(negedge clk);
        while (bus.stall && n_st < 60) begin
            n_st++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        check_result("halt_mul", er, e0, een, ed);
        chk("halt_mul.stall_cycles", 32'(n_st), 32'(MD_ITER + 4));

        // Reset in the middle of a divide, at count 8.
        drive(ALU_DIV, 16'd30000, 16'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(ALU_ADD, 16'd3, 16'd4);
        #1;
        chk("rst_busy.stall", 32'(bus.stall), 32'h0);
        chk("rst_busy.result", 32'(bus.out_alu_result), 32'h0);
        chk("rst_busy.R0_data", 32'(bus.out_R0_data), 32'h0);
        chk("rst_busy.ctrl", ctrl_out(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst_add", ALU_ADD, 16'd10, 16'd20);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) op = $urandom_range(0, 1) ? ALU_MUL : ALU_DIV;
            else op = control_e'($urandom_range(0, 10));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (op == ALU_DIV && $urandom_range(0, 4) == 0) rb = 16'h0;
            apply("random", op, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
